// File: rtl/uart_baud_pkg.sv
// Shared encodings, widths and helpers for the fractional baud generator.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package uart_baud_pkg;

  localparam int DIV_INT_W_DEF  = 16;
  localparam int DIV_FRAC_W_DEF = 4;
  localparam int OSR_CNT_W      = 4;

  typedef enum logic [1:0] {
    OSR_X16  = 2'd0,
    OSR_X8   = 2'd1,
    OSR_X4   = 2'd2,
    OSR_RSVD = 2'd3
  } osr_e;

  // Oversample ratio as a count; the reserved encoding falls back to x16.
  function automatic logic [OSR_CNT_W:0] osr_decode(input osr_e osr);
    case (osr)
      OSR_X8:  return (OSR_CNT_W+1)'(8);
      OSR_X4:  return (OSR_CNT_W+1)'(4);
      default: return (OSR_CNT_W+1)'(16);
    endcase
  endfunction

  // Reset divisor in fixed point (integer part above frac_w fraction bits),
  // rounded to nearest: clk_hz / (baud * 16).
  function automatic int unsigned reset_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned frac_w);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(clk_hz) << frac_w;
    den = 64'(baud) * 64'd16;
    return 32'((num + (den >> 1)) / den);
  endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// Clock counter plus fractional accumulator producing the oversample tick.
// Latency: tick_os registered; tick_due is the same-cycle "tick next edge" flag.
// Backpressure: none; en=0 or clear holds counter and accumulator at zero.
module uart_frac_divider #(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  output logic                  tick_due,
  output logic                  tick_os
);

  logic [DIV_INT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_FRAC_W-1:0] acc_q, acc_d;
  logic                  tick_q;
  logic [DIV_FRAC_W:0]   acc_sum;
  logic [DIV_INT_W-1:0]  int_eff;
  logic [DIV_INT_W-1:0]  cnt_last;

  // The carry of this period's accumulator add stretches the period by one clock.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, div_frac};
  assign int_eff  = (div_int < DIV_INT_W'(2)) ? DIV_INT_W'(2) : div_int;
  assign cnt_last = int_eff - DIV_INT_W'(1) + DIV_INT_W'(acc_sum[DIV_FRAC_W]);
  assign tick_due = en && !clear && (cnt_q == cnt_last);
  assign tick_os  = tick_q;

  // Next state: count up, wrap and commit the accumulator at end of period.
  always_comb begin
    cnt_d = cnt_q + DIV_INT_W'(1);
    acc_d = acc_q;
    if (!en || clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (tick_due) begin
      cnt_d = '0;
      acc_d = acc_sum[DIV_FRAC_W-1:0];
    end
  end

  // Counter, accumulator and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      tick_q <= tick_due;
    end
  end

endmodule

// File: rtl/uart_frac_baud_gen.sv
// Fractional baud generator: oversample, mid-bit and bit ticks from a shadowed config.
// Latency: all ticks registered; first tick_os P clocks after en is raised.
// Backpressure: none; new config waits in a shadow until the next bit boundary.
module uart_frac_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 1600000,
  parameter int unsigned BAUD_RATE  = 10000,
  parameter int          DIV_INT_W  = DIV_INT_W_DEF,
  parameter int          DIV_FRAC_W = DIV_FRAC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  resync,
  input  logic                  cfg_wr,
  input  logic [DIV_INT_W-1:0]  cfg_div_int,
  input  logic [DIV_FRAC_W-1:0] cfg_div_frac,
  input  logic [1:0]            cfg_osr,
  output logic                  cfg_pending,
  output logic                  tick_os,
  output logic                  tick_mid,
  output logic                  tick_bit
);

  localparam int unsigned RST_FIX = reset_div(CLOCK_FREQ, BAUD_RATE, DIV_FRAC_W);
  localparam logic [DIV_INT_W-1:0]  RST_INT  = DIV_INT_W'(RST_FIX >> DIV_FRAC_W);
  localparam logic [DIV_FRAC_W-1:0] RST_FRAC = DIV_FRAC_W'(RST_FIX);

  logic [DIV_INT_W-1:0]  act_int_q, sh_int_q;
  logic [DIV_FRAC_W-1:0] act_frac_q, sh_frac_q;
  osr_e                  act_osr_q, sh_osr_q;
  logic                  pending_q, pending_d;
  logic [OSR_CNT_W-1:0]  osr_cnt_q, osr_cnt_d;
  logic                  tick_mid_q, tick_mid_d;
  logic                  tick_bit_q, tick_bit_d;
  logic                  tick_due;
  logic                  apply;
  logic [OSR_CNT_W:0]    osr_n;
  logic [OSR_CNT_W-1:0]  osr_last;
  logic [OSR_CNT_W-1:0]  osr_mid;

  uart_frac_divider #(
    .DIV_INT_W  (DIV_INT_W),
    .DIV_FRAC_W (DIV_FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (resync),
    .div_int  (act_int_q),
    .div_frac (act_frac_q),
    .tick_due (tick_due),
    .tick_os  (tick_os)
  );

  assign osr_n    = osr_decode(act_osr_q);
  assign osr_last = OSR_CNT_W'(osr_n - (OSR_CNT_W+1)'(1));
  assign osr_mid  = OSR_CNT_W'((osr_n >> 1) - (OSR_CNT_W+1)'(1));

  // Shadow is safe to apply while idle, at a bit boundary, or on a phase restart.
  assign apply     = pending_q && (resync || !en || tick_bit_q);
  assign pending_d = cfg_wr || (pending_q && !apply);

  assign cfg_pending = pending_q;
  assign tick_mid    = tick_mid_q;
  assign tick_bit    = tick_bit_q;

  // Oversample counter next state; mid/bit ticks line up with the tick_os that causes them.
  always_comb begin
    osr_cnt_d  = osr_cnt_q;
    tick_mid_d = 1'b0;
    tick_bit_d = 1'b0;
    if (!en || resync) begin
      osr_cnt_d = '0;
    end else if (tick_due) begin
      tick_mid_d = (osr_cnt_q == osr_mid);
      tick_bit_d = (osr_cnt_q == osr_last);
      osr_cnt_d  = tick_bit_d ? '0 : osr_cnt_q + OSR_CNT_W'(1);
    end
  end

  // Oversample counter and registered mid/bit ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osr_cnt_q  <= '0;
      tick_mid_q <= 1'b0;
      tick_bit_q <= 1'b0;
    end else begin
      osr_cnt_q  <= osr_cnt_d;
      tick_mid_q <= tick_mid_d;
      tick_bit_q <= tick_bit_d;
    end
  end

  // Shadow capture and apply; a write on an apply cycle lands in the shadow after the old one moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int_q  <= RST_INT;
      act_frac_q <= RST_FRAC;
      act_osr_q  <= OSR_X16;
      sh_int_q   <= RST_INT;
      sh_frac_q  <= RST_FRAC;
      sh_osr_q   <= OSR_X16;
      pending_q  <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_int_q  <= cfg_div_int;
        sh_frac_q <= cfg_div_frac;
        sh_osr_q  <= osr_e'(cfg_osr);
      end
      if (apply) begin
        act_int_q  <= sh_int_q;
        act_frac_q <= sh_frac_q;
        act_osr_q  <= sh_osr_q;
      end
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Self-checking bench: tick timestamps compared against an event-time reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_frac_baud_gen;

  localparam int IW     = 16;
  localparam int FW     = 4;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int BIG    = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          resync = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [IW-1:0] cfg_div_int = '0;
  logic [FW-1:0] cfg_div_frac = '0;
  logic [1:0]    cfg_osr = '0;
  logic          cfg_pending, tick_os, tick_mid, tick_bit;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int m_int, m_frac, m_osr, m_acc;
  int exp_q[3][$];
  int obs_q[3][$];
  string qn[3] = '{"tick_os", "tick_mid", "tick_bit"};

  uart_frac_baud_gen #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DIV_INT_W  (IW),
    .DIV_FRAC_W (FW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .resync       (resync),
    .cfg_wr       (cfg_wr),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_osr      (cfg_osr),
    .cfg_pending  (cfg_pending),
    .tick_os      (tick_os),
    .tick_mid     (tick_mid),
    .tick_bit     (tick_bit)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc++;

  // Timestamp every tick, sampled mid-cycle.
  always @(negedge clk) begin
    if (tick_os)  obs_q[0].push_back(cyc);
    if (tick_mid) obs_q[1].push_back(cyc);
    if (tick_bit) obs_q[2].push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: period = max(int,2) + carry(acc+frac), ticks counted per bit.
  task automatic plan(input int s, input int nbits, input int limit, output int t_end);
    int t;
    int osr;
    int sum;
    t   = s;
    osr = (m_osr == 1) ? 8 : (m_osr == 2) ? 4 : 16;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 1; k <= osr; k++) begin
        sum   = m_acc + m_frac;
        t     = t + ((m_int < 2) ? 2 : m_int) + ((sum >= 16) ? 1 : 0);
        m_acc = sum % 16;
        if (t < limit) begin
          exp_q[0].push_back(t);
          if (k == osr / 2) exp_q[1].push_back(t);
          if (k == osr)     exp_q[2].push_back(t);
        end
      end
    end
    t_end = t;
  endtask

  task automatic compare_all(input string scen);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("%s_%s_count", scen, qn[k]), obs_q[k].size(), exp_q[k].size());
      for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++)
        check_val($sformatf("%s_%s_%0d", scen, qn[k], i), obs_q[k][i], exp_q[k][i]);
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) check_val("schedule", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_cfg(input int i, input int f, input int o);
    cfg_div_int  = i[IW-1:0];
    cfg_div_frac = f[FW-1:0];
    cfg_osr      = o[1:0];
  endtask

  // Write while idle: pending for exactly one cycle, then active.
  task automatic write_idle_cfg(input int i, input int f, input int o, input string tag);
    en     = 1'b0;
    cfg_wr = 1'b1;
    set_cfg(i, f, o);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_val({tag, "_pend_set"}, cfg_pending, 1);
    @(negedge clk);
    check_val({tag, "_pend_clr"}, cfg_pending, 0);
    m_int = i; m_frac = f; m_osr = o; m_acc = 0;
  endtask

  task automatic reset_model();
    m_int  = CLK_HZ / (BAUD * 16);
    m_frac = ((CLK_HZ * 16 + BAUD * 8) / (BAUD * 16)) % 16;
    m_osr  = 0;
    m_acc  = 0;
  endtask

  int s, t, t1, t2, tmp, er;
  int ci, cf, co;
  int tab_int[3]  = '{10, 0, 1};
  int tab_frac[3] = '{8, 0, 0};
  int tab_osr[3]  = '{0, 0, 3};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tick_os", tick_os, 0);
    check_val("rst_tick_mid", tick_mid, 0);
    check_val("rst_tick_bit", tick_bit, 0);
    check_val("rst_pending", cfg_pending, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Defaults for three bits, then a mid-bit write and a write on the apply cycle
    reset_model();
    en = 1'b1;
    s  = cyc;
    plan(s, 3, BIG, t);
    wait_cyc(t + 37);
    cfg_wr = 1'b1;
    set_cfg(20, 0, 1);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_val("mid_pend_set", cfg_pending, 1);
    plan(t, 1, BIG, t1);
    wait_cyc(t1);
    check_val("mid_pend_at_bit", cfg_pending, 1);
    ci = $urandom_range(3, 12); cf = $urandom_range(0, 15); co = $urandom_range(0, 3);
    cfg_wr = 1'b1;
    set_cfg(ci, cf, co);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_val("apply_cyc_pend", cfg_pending, 1);
    m_int = 20; m_frac = 0; m_osr = 1;
    plan(t1, 1, BIG, t2);
    wait_cyc(t2);
    check_val("b_pend_at_bit", cfg_pending, 1);
    @(negedge clk);
    check_val("b_pend_clr", cfg_pending, 0);
    m_int = ci; m_frac = cf; m_osr = co;
    plan(t2, 2, BIG, t);
    wait_cyc(t);
    en = 1'b0;
    @(negedge clk);
    compare_all("dflt_mid");

    // Idle writes: directed table (frac 8/16, clamp 0 and 1, reserved OSR) then random
    for (int n = 0; n < 8; n++) begin
      if (n < 3) begin
        ci = tab_int[n]; cf = tab_frac[n]; co = tab_osr[n];
      end else begin
        ci = $urandom_range(0, 12); cf = $urandom_range(0, 15); co = $urandom_range(0, 3);
      end
      write_idle_cfg(ci, cf, co, $sformatf("cfg%0d", n));
      en = 1'b1;
      s  = cyc;
      plan(s, 2, BIG, t);
      wait_cyc(t);
      en = 1'b0;
      @(negedge clk);
      compare_all($sformatf("cfg%0d", n));
    end

    // Resync mid-bit, then resync on a tick edge while a write is pending
    write_idle_cfg(10, 0, 0, "rs");
    en = 1'b1;
    s  = cyc;
    plan(s, 1, BIG, t);
    plan(t, 1, t + 37, tmp);
    wait_cyc(t + 36);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    er    = cyc;
    m_acc = 0;
    plan(er, 1, er + 50, tmp);
    wait_cyc(er + 45);
    cfg_wr = 1'b1;
    set_cfg(20, 0, 1);
    @(negedge clk);
    cfg_wr = 1'b0;
    @(negedge clk);
    check_val("rs_pend_set", cfg_pending, 1);
    wait_cyc(er + 49);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    check_val("rs_pend_clr", cfg_pending, 0);
    m_int = 20; m_frac = 0; m_osr = 1; m_acc = 0;
    plan(er + 50, 2, BIG, t);
    wait_cyc(t);
    en = 1'b0;
    @(negedge clk);
    compare_all("resync");

    // Asynchronous reset on a bit tick with a write pending
    write_idle_cfg(5, 3, 2, "ar");
    en = 1'b1;
    s  = cyc;
    plan(s, 2, BIG, t);
    wait_cyc(t - 3);
    cfg_wr = 1'b1;
    set_cfg(7, 0, 0);
    @(negedge clk);
    cfg_wr = 1'b0;
    wait_cyc(t);
    check_val("ar_pre_bit", tick_bit, 1);
    check_val("ar_pre_pend", cfg_pending, 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("ar_tick_os", tick_os, 0);
    check_val("ar_tick_mid", tick_mid, 0);
    check_val("ar_tick_bit", tick_bit, 0);
    check_val("ar_pending", cfg_pending, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compare_all("ar_run");
    @(negedge clk);
    reset_model();
    en = 1'b1;
    s  = cyc;
    plan(s, 1, BIG, t);
    wait_cyc(t);
    en = 1'b0;
    @(negedge clk);
    compare_all("ar_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
